pc_unit: RTL

Parametrised program-counter stage that generates fetch addresses for the instruction memory. It supports a configurable reset vector, instruction size and address width. It adds pipeline stall, branch/jump redirect, a one-deep pending-redirect buffer for redirects that arrive during a stall, and a highest-priority flush (exception/eret) redirect. It sits at the front of the pipeline, feeding program_counter and chip_enable to the instruction fetch path.

---
 rtl/pc_unit.sv | 73 +++++++
 1 files changed

// File: rtl/pc_unit.sv
// Program-counter stage: produces fetch addresses with stall, branch redirect,
// a one-deep buffered redirect for branches seen during a stall, and flush.
module pc_unit #(
  parameter int unsigned                 ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0]       RESET_VECTOR = '0,
  parameter int unsigned                 INST_BYTES   = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_target,
  input  logic                  branch_valid,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  output logic [ADDR_WIDTH-1:0] program_counter,
  output logic                  chip_enable,
  output logic                  redirect_pending
);

  localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(INST_BYTES);
  // INST_BYTES is a power of two, so STEP-1 covers exactly the offset bits.
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(STEP - ADDR_WIDTH'(1));

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic                  ce_q, ce_d;
  logic                  pend_q, pend_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_VECTOR;
      pend_tgt_q <= '0;
      ce_q       <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_tgt_q <= pend_tgt_d;
      ce_q       <= ce_d;
      pend_q     <= pend_d;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    pend_tgt_d = pend_tgt_q;
    ce_d       = ce_q;
    pend_d     = pend_q;

    if (!ce_q) begin
      // First edge out of reset only enables fetch; PC stays on the vector.
      ce_d = 1'b1;
    end else if (flush) begin
      pc_d   = flush_target & ALIGN_MASK;
      pend_d = 1'b0;
    end else if (branch_valid && !stall) begin
      pc_d   = branch_target & ALIGN_MASK;
      pend_d = 1'b0;
    end else if (branch_valid) begin
      pend_tgt_d = branch_target & ALIGN_MASK;
      pend_d     = 1'b1;
    end else if (pend_q && !stall) begin
      pc_d   = pend_tgt_q;
      pend_d = 1'b0;
    end else if (!stall) begin
      pc_d = pc_q + STEP;
    end
  end

  assign program_counter  = pc_q;
  assign chip_enable      = ce_q;
  assign redirect_pending = pend_q;

endmodule
